// File: rtl/fetch_if.sv
// fetch_if: fetch-stage control, instruction-memory and IF/ID bundle.
interface fetch_if #(
    parameter int PCW        = 7,
    parameter int INST_WIDTH = 32
);
    logic                  stall_i;
    logic                  br_taken_i;
    logic [PCW-1:0]        br_target_i;
    logic [PCW-1:0]        imem_addr_o;
    logic [INST_WIDTH-1:0] imem_data_i;
    logic [INST_WIDTH-1:0] inst_o;
    logic [PCW-1:0]        pc_o;
    logic [PCW-1:0]        pc_plus1_o;
    logic                  valid_o;
    logic                  ras_err_o;
    modport master (
        output stall_i, br_taken_i, br_target_i, imem_data_i,
        input  imem_addr_o, inst_o, pc_o, pc_plus1_o, valid_o, ras_err_o
    );
    modport slave (
        input  stall_i, br_taken_i, br_target_i, imem_data_i,
        output imem_addr_o, inst_o, pc_o, pc_plus1_o, valid_o, ras_err_o
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, JUMP/JAL/RET pre-decode with return-address stack, IF/ID register.
module fetch_stage #(
    parameter int INST_WIDTH   = 32,
    parameter int MAX_NUM_INST = 128,
    parameter int RAS_DEPTH    = 4
) (
    input logic   clk,
    input logic   rst,
    fetch_if.slave f
);
    localparam int PCW = $clog2(MAX_NUM_INST);
    localparam int AW  = $clog2(RAS_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [5:0] OP_JUMP = 6'b111000;
    localparam logic [5:0] OP_JAL  = 6'b111001;
    localparam logic [5:0] OP_RET  = 6'b111010;
    logic [PCW-1:0]        pc_q, pc_d, pco_q, pco_d, pc1_q, pc1_d, pc_inc, tgt, ras_top;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  valid_q, valid_d, err_q, err_d, push, pop;
    logic [5:0]            opc;
    logic [PCW-1:0]        ras_q [RAS_DEPTH];
    logic [AW-1:0]         top_q;
    logic [CW-1:0]         cnt_q;
    // top_q is the next free slot; the newest entry sits one below it
    assign opc     = f.imem_data_i[INST_WIDTH-1 -: 6];
    assign tgt     = f.imem_data_i[PCW-1:0];
    assign pc_inc  = pc_q + PCW'(1);
    assign ras_top = ras_q[top_q - AW'(1)];
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        pco_d   = pco_q;
        pc1_d   = pc1_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        if (f.br_taken_i) begin
            pc_d    = f.br_target_i;
            valid_d = 1'b0;
        end else if (!f.stall_i) begin
            inst_d  = f.imem_data_i;
            pco_d   = pc_q;
            pc1_d   = pc_inc;
            valid_d = 1'b1;
            push    = opc == OP_JAL;
            pop     = opc == OP_RET && cnt_q != '0;
            err_d   = opc == OP_RET && cnt_q == '0;
            pc_d    = (opc == OP_JUMP || push) ? tgt : pop ? ras_top : pc_inc;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            inst_q  <= '0;
            pco_q   <= '0;
            pc1_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pco_q   <= pco_d;
            pc1_q   <= pc1_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
    // a push on a full stack overwrites the oldest slot, which is where top_q already points
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            top_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            ras_q[top_q] <= pc_inc;
            top_q        <= top_q + AW'(1);
            cnt_q        <= (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1);
        end else if (pop) begin
            top_q <= top_q - AW'(1);
            cnt_q <= cnt_q - CW'(1);
        end
    end
    assign f.imem_addr_o = pc_q;
    assign f.inst_o      = inst_q;
    assign f.pc_o        = pco_q;
    assign f.pc_plus1_o  = pc1_q;
    assign f.valid_o     = valid_q;
    assign f.ras_err_o   = err_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench; a queue-based fetch model predicts PC and IF/ID every cycle.
module tb_fetch_stage;
    localparam int PCW = 7;
    localparam int IW  = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fetch_if #(.PCW(PCW), .INST_WIDTH(IW)) f();
    fetch_stage dut (.clk(clk), .rst(rst), .f(f));
    logic [31:0] mem [128];
    assign f.imem_data_i = mem[f.imem_addr_o];
    typedef struct packed {
        logic [6:0]  pc;
        logic [31:0] inst;
        logic [6:0]  pco;
        logic [6:0]  pc1;
        logic        valid;
        logic        err;
    } exp_t;
    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int          m_pc, m_pco, m_pc1;
    logic [31:0] m_inst;
    bit          m_valid, m_err;
    int          ras[$];
    function automatic logic [31:0] ins(input logic [5:0] op, input int t);
        return {op, 19'($urandom), t[6:0]};
    endfunction
    function automatic exp_t model_state();
        return {m_pc[6:0], m_inst, m_pco[6:0], m_pc1[6:0], m_valid, m_err};
    endfunction
    function automatic exp_t actual();
        return {f.imem_addr_o, f.inst_o, f.pc_o, f.pc_plus1_o, f.valid_o, f.ras_err_o};
    endfunction
    task automatic show_fail(input string name, input exp_t a, input exp_t e);
        $display("FAIL %s: got pc=%0h inst=%h pc_o=%0h pc1=%0h valid=%0b err=%0b, want pc=%0h inst=%h pc_o=%0h pc1=%0h valid=%0b err=%0b",
                 name, a.pc, a.inst, a.pco, a.pc1, a.valid, a.err, e.pc, e.inst, e.pco, e.pc1, e.valid, e.err);
    endtask
    // Entered and left at negedge+2: drive, predict the next edge, queue the prediction.
    task automatic step(input bit st, input bit br, input int tgt);
        logic [31:0] d;
        f.stall_i     = st;
        f.br_taken_i  = br;
        f.br_target_i = tgt[6:0];
        #1;
        d     = mem[m_pc];
        m_err = 1'b0;
        if (br) begin
            m_pc    = tgt;
            m_valid = 1'b0;
        end else if (!st) begin
            m_inst  = d;
            m_pco   = m_pc;
            m_pc1   = (m_pc + 1) % 128;
            m_valid = 1'b1;
            case (int'(d[31:26]))
                56: m_pc = d[6:0];
                57: begin
                    ras.push_back(m_pc1);
                    if (ras.size() > 4) void'(ras.pop_front());
                    m_pc = d[6:0];
                end
                58: if (ras.size() > 0) m_pc = ras.pop_back();
                    else begin m_pc = m_pc1; m_err = 1'b1; end
                default: m_pc = m_pc1;
            endcase
        end
        q.push_back(model_state());
        @(negedge clk);
        #2;
    endtask
    task automatic do_reset();
        rst           = 1'b1;
        f.stall_i     = 1'b0;
        f.br_taken_i  = 1'b0;
        f.br_target_i = '0;
        #1;
        vectors++;
        if (actual() !== exp_t'(0)) begin
            miscompares++;
            show_fail("async_reset", actual(), exp_t'(0));
        end
        m_pc = 0; m_pco = 0; m_pc1 = 0; m_inst = '0; m_valid = 1'b0; m_err = 1'b0;
        ras.delete();
        q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask
    always @(negedge clk) begin
        exp_t e, a;
        if (!rst && q.size() != 0) begin
            e = q.pop_front();
            a = actual();
            vectors++;
            if (a !== e) begin
                miscompares++;
                show_fail("fetch_cycle", a, e);
            end
        end
    end
    initial begin
        int n;
        f.stall_i = 1'b0; f.br_taken_i = 1'b0; f.br_target_i = '0;
        for (int i = 0; i < 128; i++) mem[i] = ins(6'd0, $urandom);
        @(negedge clk);
        #2;
        do_reset();
        // Directed program: jump, call/return, nested calls overflowing the RAS, empty RET.
        mem[3]    = ins(6'b111000, 'h40);
        mem['h45] = ins(6'b111000, 5);
        mem[5]    = ins(6'b111001, 'h20);
        mem['h22] = ins(6'b111010, 0);
        mem[6]    = ins(6'b111000, 'h61);
        mem['h61] = ins(6'b111001, 'h63);
        mem['h63] = ins(6'b111001, 'h65);
        mem['h65] = ins(6'b111001, 'h67);
        mem['h67] = ins(6'b111001, 'h69);
        mem['h69] = ins(6'b111001, 'h70);
        mem['h70] = ins(6'b111010, 0);
        mem['h6a] = ins(6'b111010, 0);
        mem['h68] = ins(6'b111010, 0);
        mem['h66] = ins(6'b111010, 0);
        mem['h64] = ins(6'b111010, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 0);
        n = 0;
        while (ras.size() != 2 && n < 40) begin step(0, 0, 0); n++; end
        do_reset();
        // Stall window with a branch redirect in the middle.
        for (int i = 0; i < 128; i++) mem[i] = ins(6'd0, $urandom);
        n = 0;
        while (m_pc != 10 && n < 20) begin step(0, 0, 0); n++; end
        step(1, 0, 0);
        step(1, 1, 'h50);
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        // PC wrap through 127 -> 0.
        mem[m_pc] = ins(6'b111000, 126);
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        // Random programs with random stalls and branch redirects.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int i = 0; i < 128; i++) begin
                int r;
                r = $urandom_range(0, 99);
                mem[i] = r < 12 ? ins(6'b111000, $urandom) :
                         r < 26 ? ins(6'b111001, $urandom) :
                         r < 42 ? ins(6'b111010, $urandom) :
                         r < 50 ? ins(6'b000100, $urandom) :
                                  ins(6'($urandom_range(0, 55)), $urandom);
            end
            for (int i = 0; i < 1500; i++)
                step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10, $urandom_range(0, 127));
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d predictions left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
